// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared types and constants for the switch debouncer (SW_DEBOUNCE_EDGE_EN enables rise/fall pulses)
package sw_debounce_pkg;
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} sw_db_state_t;
  localparam int SW_DB_DEFAULT_STABLE_CYCLES = 1000000;
  localparam int SW_DB_SYNC_STAGES = 2;
endpackage

// File: rtl/sw_db_cell.sv
// sw_db_cell: one debounced channel (synchroniser, hold counter, FSM, optional SW_DEBOUNCE_EDGE_EN pulse flops)
module sw_db_cell
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_DB_DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic [SW_DB_SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  sw_db_state_t state;
  logic s2, accept_hi, accept_lo;
  assign s2 = sync[SW_DB_SYNC_STAGES-1];
  assign accept_hi = (state == WAIT_HI) && s2 && (cnt == LAST);
  assign accept_lo = (state == WAIT_LO) && !s2 && (cnt == LAST);
  // bring the raw level into the clock domain
  always_ff @(posedge clk)
    sync <= rst ? '0 : {sync[SW_DB_SYNC_STAGES-2:0], in};
  // qualify each new level for STABLE_CYCLES cycles; any bounce restarts from scratch
  always_ff @(posedge clk)
    if (rst) begin
      state <= STABLE_LO;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: if (s2) begin state <= WAIT_HI; cnt <= '0; end
        WAIT_HI:
          if (!s2) state <= STABLE_LO;
          else if (accept_hi) begin state <= STABLE_HI; out <= 1'b1; end
          else cnt <= cnt + CW'(1);
        STABLE_HI: if (!s2) begin state <= WAIT_LO; cnt <= '0; end
        default:
          if (s2) state <= STABLE_HI;
          else if (accept_lo) begin state <= STABLE_LO; out <= 1'b0; end
          else cnt <= cnt + CW'(1);
      endcase
    end
`ifdef SW_DEBOUNCE_EDGE_EN
  // one-cycle pulses coincide with the registered output change
  always_ff @(posedge clk)
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept_hi;
      fall <= accept_lo;
    end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: N independent switch debouncers (rise/fall pulses built only with SW_DEBOUNCE_EDGE_EN)
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N = 1,
  parameter int STABLE_CYCLES = SW_DB_DEFAULT_STABLE_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    sw_db_cell #(.STABLE_CYCLES(STABLE_CYCLES)) u_cell (
      .clk (clk),
      .rst (rst),
      .in  (in[i]),
      .out (out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of sw_debounce with N=2, STABLE_CYCLES=4
module tb_sw_debounce;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam logic [1:0] EM = 2'b11;
`else
  localparam logic [1:0] EM = 2'b00;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] in = 2'b00;
  logic [1:0] out, rise, fall;
  int n_cmp = 0;
  int n_bad = 0;

  sw_debounce #(.N(2), .STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [1:0] o, input logic [1:0] r, input logic [1:0] f);
    chk({tag, ".out"}, out, o);
    chk({tag, ".rise"}, rise, r & EM);
    chk({tag, ".fall"}, fall, f & EM);
  endtask

  initial begin
    bit [4:0] pat;
    pat = 5'b10101;
    // reset held with both switches pressed
    in = 2'b11;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk3("reset", 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk3("post_reset", (k >= 7) ? 2'b11 : 2'b00, (k == 7) ? 2'b11 : 2'b00, 2'b00);
    end
    in = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk3("release_both", (k >= 7) ? 2'b00 : 2'b11, 2'b00, (k == 7) ? 2'b11 : 2'b00);
    end
    // clean press and release on channel 0
    in = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk3("press0", (k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00, 2'b00);
    end
    in = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk3("release0", (k >= 7) ? 2'b00 : 2'b01, 2'b00, (k == 7) ? 2'b01 : 2'b00);
    end
    // bounce 1,0,1,0,1 then hold: final rising transition is before edge 5
    for (int k = 1; k <= 16; k++) begin
      in = {1'b0, (k <= 5) ? pat[k-1] : 1'b1};
      step();
      chk3("bounce", (k >= 11) ? 2'b01 : 2'b00, (k == 11) ? 2'b01 : 2'b00, 2'b00);
    end
    in = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk3("bounce_rel", (k >= 7) ? 2'b00 : 2'b01, 2'b00, (k == 7) ? 2'b01 : 2'b00);
    end
    // 4-cycle glitch on channel 1 never qualifies
    for (int k = 1; k <= 14; k++) begin
      in = (k <= 4) ? 2'b10 : 2'b00;
      step();
      chk3("glitch1", 2'b00, 2'b00, 2'b00);
    end
    // reset sampled at edge 5 aborts qualification
    in = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk3("midq_pre", 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b1;
    step();
    chk3("midq_rst", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk3("midq_post", (k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00, 2'b00);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
